// File: rtl/fft64_result_unloader.sv
// Captures a parallel FFT result frame on the rising edge of done and streams it one sample per beat.
// Latency: first sample valid the cycle after done is first seen high; one beat per cycle thereafter.
// Backpressure: m_valid/m_ready handshake, outputs hold while stalled; rises during a frame set overrun.
module fft64_result_unloader #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 64,
    parameter bit BIT_REV    = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              done,
    input  logic [N_POINTS*DATA_WIDTH-1:0]    din_real,
    input  logic [N_POINTS*DATA_WIDTH-1:0]    din_imag,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_real,
    output logic [DATA_WIDTH-1:0]             m_imag,
    output logic [$clog2(N_POINTS)-1:0]       m_index,
    output logic                              m_last,
    output logic                              busy,
    output logic                              overrun,
    input  logic                              clr_overrun
);

    localparam int AW = $clog2(N_POINTS);
    localparam logic [AW-1:0] LAST_CNT = AW'(N_POINTS - 1);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                          state;
    logic [AW-1:0]                   cnt;
    logic [AW-1:0]                   cnt_nxt;
    logic [AW-1:0]                   idx_nxt;
    logic                            done_d;
    logic                            rise;
    logic                            xfer;
    logic [N_POINTS*DATA_WIDTH-1:0]  frame_real;
    logic [N_POINTS*DATA_WIDTH-1:0]  frame_imag;

    // Mirror the index bits so cores with bit-reversed output are streamed in natural order.
    function automatic logic [AW-1:0] bit_rev(input logic [AW-1:0] v);
        logic [AW-1:0] r;
        for (int b = 0; b < AW; b++) begin
            r[b] = v[AW-1-b];
        end
        return r;
    endfunction

    assign rise    = done & ~done_d;
    assign xfer    = m_valid & m_ready;
    assign cnt_nxt = cnt + AW'(1);
    assign idx_nxt = BIT_REV ? bit_rev(cnt_nxt) : cnt_nxt;

    // Frame buffer: loaded only on a rise seen while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && rise) begin
            frame_real <= din_real;
            frame_imag <= din_imag;
        end
    end

    // Control FSM with registered stream outputs and sticky overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            done_d  <= 1'b0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
            m_index <= '0;
        end else begin
            done_d <= done;

            // A rise is only lost while a frame is held, including its final beat; set beats clear.
            if (rise && state == STREAM) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        // Beat 0 maps to index 0 in both orders, so present it straight from din.
                        state   <= STREAM;
                        cnt     <= '0;
                        m_valid <= 1'b1;
                        busy    <= 1'b1;
                        m_last  <= 1'b0;
                        m_index <= '0;
                        m_real  <= din_real[0 +: DATA_WIDTH];
                        m_imag  <= din_imag[0 +: DATA_WIDTH];
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (m_last) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            m_valid <= 1'b0;
                            busy    <= 1'b0;
                            m_last  <= 1'b0;
                            m_index <= '0;
                            m_real  <= '0;
                            m_imag  <= '0;
                        end else begin
                            cnt     <= cnt_nxt;
                            m_index <= idx_nxt;
                            m_real  <= frame_real[idx_nxt*DATA_WIDTH +: DATA_WIDTH];
                            m_imag  <= frame_imag[idx_nxt*DATA_WIDTH +: DATA_WIDTH];
                            m_last  <= (cnt_nxt == LAST_CNT);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft64_result_unloader.sv
module tb_fft64_result_unloader;

    localparam int W = 16;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst_n, done, m_ready, clr_overrun;
    logic [N*W-1:0] din_real, din_imag;

    logic v0, l0, b0, o0, v1, l1, b1, o1;
    logic [W-1:0] r0, i0, r1, i1;
    logic [5:0] x0, x1;

    logic [40:0] obs0, obs1;
    assign obs0 = {v0, b0, l0, x0, r0, i0};
    assign obs1 = {v1, b1, l1, x1, r1, i1};

    int errors = 0;
    int checks = 0;

    int fr_re[N];
    int fr_im[N];
    int nb_re[N];
    int nb_im[N];

    always #5 clk = ~clk;

    fft64_result_unloader #(.DATA_WIDTH(W), .N_POINTS(N), .BIT_REV(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .done(done), .din_real(din_real), .din_imag(din_imag),
        .m_valid(v0), .m_ready(m_ready), .m_real(r0), .m_imag(i0), .m_index(x0),
        .m_last(l0), .busy(b0), .overrun(o0), .clr_overrun(clr_overrun)
    );

    fft64_result_unloader #(.DATA_WIDTH(W), .N_POINTS(N), .BIT_REV(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .done(done), .din_real(din_real), .din_imag(din_imag),
        .m_valid(v1), .m_ready(m_ready), .m_real(r1), .m_imag(i1), .m_index(x1),
        .m_last(l1), .busy(b1), .overrun(o1), .clr_overrun(clr_overrun)
    );

    // Reference bit reversal over 6 bits, by repeated division.
    function automatic int rev6(input int k);
        int r;
        int v;
        r = 0;
        v = k;
        for (int b = 0; b < 6; b++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    // Expected {valid, busy, last, index, real, imag} for beat k of the frame held in fr_re/fr_im.
    function automatic logic [40:0] exp_beat(input int k, input bit rev);
        int idx;
        logic [5:0] ix;
        logic [W-1:0] re;
        logic [W-1:0] im;
        idx = rev ? rev6(k) : k;
        ix  = idx[5:0];
        re  = fr_re[idx][W-1:0];
        im  = fr_im[idx][W-1:0];
        return {1'b1, 1'b1, (k == N - 1), ix, re, im};
    endfunction

    task automatic load_din(input int re[N], input int im[N]);
        for (int i = 0; i < N; i++) begin
            din_real[i*W +: W] = re[i][W-1:0];
            din_imag[i*W +: W] = im[i][W-1:0];
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; done = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0;
        din_real = '0; din_imag = '0;
        #12;
        checks++;
        if ({obs0, o0} !== 42'd0) $display("FAIL reset_dut0: got %h want 0", {obs0, o0});
        checks++;
        if ({obs1, o1} !== 42'd0) $display("FAIL reset_dut1: got %h want 0", {obs1, o1});
        if ({obs0, o0} !== 42'd0) errors++;
        if ({obs1, o1} !== 42'd0) errors++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_impulse();
        for (int i = 0; i < N; i++) begin fr_re[i] = 8192; fr_im[i] = 0; end
        load_din(fr_re, fr_im);
        m_ready = 1'b1;
        pulse_done();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs0 !== exp_beat(k, 1'b0)) begin
                errors++;
                $display("FAIL impulse beat %0d: got %h want %h", k, obs0, exp_beat(k, 1'b0));
            end
            @(negedge clk);
        end
        checks++;
        if (obs0 !== 41'd0) begin
            errors++;
            $display("FAIL impulse_idle_after: got %h want 0", obs0);
        end
    endtask

    task automatic test_back_pressure();
        int k;
        for (int i = 0; i < N; i++) begin fr_re[i] = i; fr_im[i] = -i; end
        load_din(fr_re, fr_im);
        pulse_done();
        k = 0;
        for (int cyc = 0; cyc < 400 && k < N; cyc++) begin
            m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            checks++;
            if (obs0 !== exp_beat(k, 1'b0)) begin
                errors++;
                $display("FAIL backpressure cyc %0d beat %0d: got %h want %h", cyc, k, obs0, exp_beat(k, 1'b0));
            end
            if (m_ready) k++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        checks++;
        if (k !== N) begin
            errors++;
            $display("FAIL backpressure_transfers: got %0d want %0d", k, N);
        end
        checks++;
        if (obs0 !== 41'd0) begin
            errors++;
            $display("FAIL backpressure_idle_after: got %h want 0", obs0);
        end
    endtask

    // Frame 0 uses real = i to show the reversed order plainly; later frames are fully random.
    task automatic test_bit_reverse_random();
        int k;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) begin
                fr_re[i] = (f == 0) ? i : int'($urandom_range(0, 65535));
                fr_im[i] = int'($urandom_range(0, 65535));
            end
            load_din(fr_re, fr_im);
            pulse_done();
            k = 0;
            for (int cyc = 0; cyc < 1000 && k < N; cyc++) begin
                m_ready = ($urandom_range(0, 3) != 0);
                checks++;
                if (obs1 !== exp_beat(k, 1'b1)) begin
                    errors++;
                    $display("FAIL bitrev frame %0d beat %0d: got %h want %h", f, k, obs1, exp_beat(k, 1'b1));
                end
                checks++;
                if (obs0 !== exp_beat(k, 1'b0)) begin
                    errors++;
                    $display("FAIL random frame %0d beat %0d: got %h want %h", f, k, obs0, exp_beat(k, 1'b0));
                end
                if (m_ready) k++;
                @(negedge clk);
            end
            m_ready = 1'b1;
            checks++;
            if (k !== N || obs1 !== 41'd0) begin
                errors++;
                $display("FAIL bitrev_frame_end %0d: transfers %0d valid %b want %0d and 0", f, k, v1, N);
            end
        end
    endtask

    task automatic test_held_done_overrun();
        int nv;
        for (int i = 0; i < N; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535));
            fr_im[i] = int'($urandom_range(0, 65535));
        end
        load_din(fr_re, fr_im);
        m_ready = 1'b1;
        done = 1'b1;
        nv = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (v0) nv++;
        end
        done = 1'b0;
        checks++;
        if (nv !== N) begin
            errors++;
            $display("FAIL held_done_beats: got %0d want %0d", nv, N);
        end
        checks++;
        if (o0 !== 1'b0) begin
            errors++;
            $display("FAIL held_done_overrun: got %b want 0", o0);
        end
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            nb_re[i] = int'($urandom_range(0, 65535));
            nb_im[i] = int'($urandom_range(0, 65535));
        end
        pulse_done();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs0 !== exp_beat(k, 1'b0)) begin
                errors++;
                $display("FAIL overrun_frame beat %0d: got %h want %h", k, obs0, exp_beat(k, 1'b0));
            end
            if (k == 11) begin
                done = 1'b0;
                clr_overrun = 1'b0;
                checks++;
                if (o0 !== 1'b1) begin
                    errors++;
                    $display("FAIL overrun_set_wins: got %b want 1", o0);
                end
            end
            if (k == 10) begin
                load_din(nb_re, nb_im);
                done = 1'b1;
                clr_overrun = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if ({obs0, o0} !== 42'd1) begin
            errors++;
            $display("FAIL overrun_sticky_idle: got %h want 1", {obs0, o0});
        end
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checks++;
        if (o0 !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b want 0", o0);
        end

        fr_re = nb_re;
        fr_im = nb_im;
        pulse_done();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs0 !== exp_beat(k, 1'b0)) begin
                errors++;
                $display("FAIL new_capture beat %0d: got %h want %h", k, obs0, exp_beat(k, 1'b0));
            end
            @(negedge clk);
        end
        checks++;
        if ({obs0, o0} !== 42'd0) begin
            errors++;
            $display("FAIL new_capture_end: got %h want 0", {obs0, o0});
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < N; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535));
            fr_im[i] = int'($urandom_range(0, 65535));
        end
        load_din(fr_re, fr_im);
        m_ready = 1'b1;
        pulse_done();
        for (int k = 0; k < 20; k++) @(negedge clk);
        checks++;
        if (obs0 !== exp_beat(20, 1'b0)) begin
            errors++;
            $display("FAIL pre_reset beat 20: got %h want %h", obs0, exp_beat(20, 1'b0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({v0, b0, l0, v1, b1, l1} !== 6'd0) begin
            errors++;
            $display("FAIL async_reset_drop: got %b want 000000", {v0, b0, l0, v1, b1, l1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (obs0 !== 41'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h want 0", obs0);
        end
        for (int i = 0; i < N; i++) begin
            fr_re[i] = int'($urandom_range(0, 65535));
            fr_im[i] = int'($urandom_range(0, 65535));
        end
        load_din(fr_re, fr_im);
        pulse_done();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (obs0 !== exp_beat(k, 1'b0)) begin
                errors++;
                $display("FAIL fresh_frame beat %0d: got %h want %h", k, obs0, exp_beat(k, 1'b0));
            end
            @(negedge clk);
        end
        checks++;
        if (obs0 !== 41'd0) begin
            errors++;
            $display("FAIL fresh_frame_end: got %h want 0", obs0);
        end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_pressure();
        test_bit_reverse_random();
        test_held_done_overrun();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
